// File: rtl/apb3_led_sequencer_pkg.sv
// Shared definitions for the APB3 LED sequencer: register offsets, CTRL/STATUS bit positions,
// timer width, FSM states and the power-on pattern table contents.
package led_seq_pkg;

  localparam int PERIOD_W = 24;

  localparam logic [7:0] OFS_CTRL    = 8'h00;
  localparam logic [7:0] OFS_PERIOD  = 8'h04;
  localparam logic [7:0] OFS_STATUS  = 8'h08;
  localparam logic [7:0] OFS_LAST    = 8'h0C;
  localparam logic [7:0] OFS_PATTERN = 8'h40;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_IRQEN = 3;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_STEP_LSB  = 4;
  localparam int STAT_DONE      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Walking-one default so an unprogrammed table still shows visible motion.
  function automatic logic [3:0] pattern_reset(int i);
    return 4'(4'b0001 << (i % 4));
  endfunction

endpackage

// File: rtl/apb3_led_sequencer_if.sv
// APB3 bus bundle for the LED sequencer; master drives the request, slave returns
// PRDATA/PREADY/PSLVERR in the same access phase.
interface apb3_led_sequencer_if #(
  parameter int ADDRWIDTH = 12
);

  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb3_led_sequencer_timer.sv
// Step timer: load max(value,1), count down while running, flag expiry when the count is 1.
// Latency: expire is combinational from the registered count; no backpressure.
module led_seq_timer
  import led_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic                dec,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                expire
);

  logic [PERIOD_W-1:0] timer_q;
  logic [PERIOD_W-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (load) begin
      timer_d = (load_val == '0) ? PERIOD_W'(1) : load_val;
    end else if (dec && (timer_q != '0)) begin
      timer_d = timer_q - PERIOD_W'(1);
    end
  end

  assign expire = dec && (timer_q == PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/apb3_led_sequencer.sv
// APB3 LED sequencer: zero-wait register file, IDLE/RUN/DONE FSM and pattern table; LED output registered.
// Build option LED_SEQ_IRQ_EN enables the IRQEN bit and the registered seqDoneIrq output.
module apb3_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int NUM_STEPS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb3_led_sequencer_if.slave  apb,
  output logic [3:0]           ledNumOut,
  output logic                 seqDoneIrq
);

  localparam logic [3:0] LAST_MAX = 4'(NUM_STEPS - 1);

  logic [ADDRWIDTH-1:0] paddr;
  logic [5:0]           widx;
  logic [3:0]           pidx;
  logic                 wr_en, rd_en, pat_hit, unused_bits;
  logic                 wr_ctrl, wr_period, wr_status, wr_last, wr_pat;
  logic                 start, stop;
  logic                 tmr_load, tmr_clear, tmr_dec, tmr_expire;
  logic [31:0]          rdata;

  seq_state_e           state_q, state_d;
  logic [3:0]           step_q, step_d, led_q, led_d, last_q, last_d;
  logic [3:0]           adv_idx, adv_pat;
  logic                 loop_q, loop_d, irqen_q, irqen_d;
  logic                 done_q, done_d, irq_q, irq_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [3:0]           pattern_q [NUM_STEPS];
  logic [3:0]           pattern_d [NUM_STEPS];

  assign paddr       = apb.PADDR;
  assign widx        = paddr[7:2];
  assign pidx        = widx[3:0];
  assign pat_hit     = (widx[5:4] == OFS_PATTERN[7:6]) && (int'(pidx) < NUM_STEPS);
  assign unused_bits = ^{paddr[ADDRWIDTH-1:8], paddr[1:0], apb.PWDATA[31:24]};

  assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en     = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign wr_ctrl   = wr_en && (widx == OFS_CTRL[7:2]);
  assign wr_period = wr_en && (widx == OFS_PERIOD[7:2]);
  assign wr_status = wr_en && (widx == OFS_STATUS[7:2]);
  assign wr_last   = wr_en && (widx == OFS_LAST[7:2]);
  assign wr_pat    = wr_en && pat_hit;
  assign start     = wr_ctrl && apb.PWDATA[CTRL_START];
  assign stop      = wr_ctrl && apb.PWDATA[CTRL_STOP];

  // Step reached on expiry: next entry, or wrap to 0 once LAST is reached.
  always_comb begin
    adv_idx = (step_q < last_q) ? step_q + 4'd1 : 4'd0;
    adv_pat = pattern_q[0];
    for (int i = 1; i < NUM_STEPS; i++) begin
      if (adv_idx == 4'(i)) adv_pat = pattern_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    led_d     = led_q;
    done_d    = done_q;
    loop_d    = loop_q;
    irqen_d   = irqen_q;
    period_d  = period_q;
    last_d    = last_q;
    pattern_d = pattern_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_dec   = (state_q == ST_RUN);

    if (wr_ctrl) begin
      loop_d = apb.PWDATA[CTRL_LOOP];
`ifdef LED_SEQ_IRQ_EN
      irqen_d = apb.PWDATA[CTRL_IRQEN];
`else
      irqen_d = 1'b0;
`endif
    end
    if (wr_period) period_d = apb.PWDATA[PERIOD_W-1:0];
    if (wr_last)   last_d   = (apb.PWDATA[3:0] > LAST_MAX) ? LAST_MAX : apb.PWDATA[3:0];
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (wr_pat && (pidx == 4'(i))) pattern_d[i] = apb.PWDATA[3:0];
    end
    if (wr_status && apb.PWDATA[STAT_DONE]) done_d = 1'b0;

    // STOP beats START; a DONE set later in this block beats the STATUS clear above.
    if (stop) begin
      state_d   = ST_IDLE;
      step_d    = 4'd0;
      led_d     = 4'd0;
      tmr_clear = 1'b1;
    end else if (start) begin
      state_d  = ST_RUN;
      step_d   = 4'd0;
      led_d    = pattern_q[0];
      tmr_load = 1'b1;
    end else if (tmr_expire) begin
      if ((step_q < last_q) || loop_q) begin
        step_d   = adv_idx;
        led_d    = adv_pat;
        tmr_load = 1'b1;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end

`ifdef LED_SEQ_IRQ_EN
    irq_d = done_d & irqen_d;
`else
    irq_d = 1'b0;
`endif
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (widx == OFS_CTRL[7:2]) begin
        rdata[CTRL_LOOP]  = loop_q;
        rdata[CTRL_IRQEN] = irqen_q;
      end else if (widx == OFS_PERIOD[7:2]) begin
        rdata[PERIOD_W-1:0] = period_q;
      end else if (widx == OFS_STATUS[7:2]) begin
        rdata[STAT_STATE_LSB +: 2] = state_q;
        rdata[STAT_STEP_LSB +: 4]  = step_q;
        rdata[STAT_DONE]           = done_q;
      end else if (widx == OFS_LAST[7:2]) begin
        rdata[3:0] = last_q;
      end else if (pat_hit) begin
        for (int i = 0; i < NUM_STEPS; i++) begin
          if (pidx == 4'(i)) rdata[3:0] = pattern_q[i];
        end
      end
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign ledNumOut   = led_q;
  assign seqDoneIrq  = irq_q;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      step_q   <= 4'd0;
      led_q    <= 4'd0;
      loop_q   <= 1'b0;
      irqen_q  <= 1'b0;
      period_q <= '0;
      last_q   <= LAST_MAX;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) pattern_q[i] <= pattern_reset(i);
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      led_q     <= led_d;
      loop_q    <= loop_d;
      irqen_q   <= irqen_d;
      period_q  <= period_d;
      last_q    <= last_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      pattern_q <= pattern_d;
    end
  end

  led_seq_timer u_timer (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (period_q),
    .expire   (tmr_expire)
  );

endmodule

// File: tb/tb_apb3_led_sequencer.sv
// Bench for apb3_led_sequencer: APB register access plus LED traces checked against a
// step-arithmetic model (step = cycles_since_start / max(PERIOD,1)).
module tb_apb3_led_sequencer;

  localparam int NS = 8;
`ifdef LED_SEQ_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [3:0] led;
  logic       irq;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [3:0] mpat [NS];

  apb3_led_sequencer_if #(.ADDRWIDTH(12)) apb_if ();

  apb3_led_sequencer #(.ADDRWIDTH(12), .NUM_STEPS(NS)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .apb        (apb_if),
    .ledNumOut  (led),
    .seqDoneIrq (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
    apb_if.PADDR = a; apb_if.PWDATA = d;
    tick(1);
    apb_if.PENABLE = 1'b1;
    tick(1);
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0; apb_if.PADDR = a;
    tick(1);
    apb_if.PENABLE = 1'b1;
    #1;
    d = apb_if.PRDATA;
    tick(1);
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
  endtask

  // Model: LED value k cycles after the START edge.
  function automatic logic [3:0] exp_led(int k, int per, int last, logic loop);
    int pe = (per == 0) ? 1 : per;
    int s  = k / pe;
    if (loop) s = s % (last + 1);
    else if (s > last) s = last;
    return mpat[s];
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    logic [3:0]  ep;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    apb_if.PADDR = '0; apb_if.PWDATA = '0;
    PRESETn = 1'b0;
    tick(3);
    PRESETn = 1'b1;
    n_cmp++; if (led !== 4'h0) begin n_fail++; $display("FAIL reset_led: got %0h want 0", led); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b want 0", irq); end
    n_cmp++; if (apb_if.PREADY !== 1'b1 || apb_if.PSLVERR !== 1'b0) begin
      n_fail++; $display("FAIL tieoffs: got pready=%0b pslverr=%0b want 1/0", apb_if.PREADY, apb_if.PSLVERR);
    end
    n_cmp++; if (apb_if.PRDATA !== 32'h0) begin n_fail++; $display("FAIL idle_prdata: got %0h want 0", apb_if.PRDATA); end
    apb_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %0h want 0", rd); end
    apb_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_period: got %0h want 0", rd); end
    apb_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL reset_last: got %0h want 7", rd); end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %0h want 0", rd); end
    for (int i = 0; i < NS; i++) begin
      ep = 4'(1 << (i % 4));
      mpat[i] = ep;
      apb_read(12'(64 + 4 * i), rd);
      n_cmp++; if (rd !== {28'd0, ep}) begin n_fail++; $display("FAIL reset_pattern%0d: got %0h want %0h", i, rd, ep); end
    end
  endtask

  task automatic test_regmap();
    logic [31:0] rd;
    apb_write(12'h004, 32'hABCDEF12);
    apb_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h00CDEF12) begin n_fail++; $display("FAIL period_rw: got %0h want cdef12", rd); end
    apb_read(12'hF04, rd);
    n_cmp++; if (rd !== 32'h00CDEF12) begin n_fail++; $display("FAIL addr_alias: got %0h want cdef12", rd); end
    apb_write(12'h00C, 32'hF);
    apb_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL last_clip: got %0h want 7", rd); end
    apb_write(12'h00C, 32'h3);
    apb_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL last_rw: got %0h want 3", rd); end
    apb_write(12'h010, 32'hFFFFFFFF);
    apb_write(12'h060, 32'hFFFFFFFF);
    apb_read(12'h010, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_010: got %0h want 0", rd); end
    apb_read(12'h060, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_060: got %0h want 0", rd); end
    apb_read(12'h040, rd);
    n_cmp++; if (rd !== {28'd0, mpat[0]}) begin n_fail++; $display("FAIL pattern0_kept: got %0h want %0h", rd, mpat[0]); end
    apb_write(12'h000, 32'hF);
    apb_read(12'h000, rd);
    n_cmp++; if (rd !== (IRQ_BUILD ? 32'hC : 32'h4)) begin
      n_fail++; $display("FAIL ctrl_read: got %0h want %0h", rd, IRQ_BUILD ? 32'hC : 32'h4);
    end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL start_stop_idle: got %0h want 0", rd); end
  endtask

  task automatic test_sequence();
    logic [31:0] rd;
    apb_write(12'h004, 32'd3);
    apb_write(12'h00C, 32'd2);
    apb_write(12'h000, 32'h1);
    for (int k = 0; k < 12; k++) begin
      n_cmp++; if (led !== exp_led(k, 3, 2, 1'b0)) begin
        n_fail++; $display("FAIL seq_led k=%0d: got %0h want %0h", k, led, exp_led(k, 3, 2, 1'b0));
      end
      tick(1);
    end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h122) begin n_fail++; $display("FAIL seq_status: got %0h want 122", rd); end
  endtask

  task automatic test_loop();
    logic [31:0] rd;
    apb_write(12'h008, 32'h100);
    apb_write(12'h004, 32'd0);
    apb_write(12'h00C, 32'd1);
    apb_write(12'h000, 32'h5);
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (led !== mpat[k % 2]) begin
        n_fail++; $display("FAIL loop_led k=%0d: got %0h want %0h", k, led, mpat[k % 2]);
      end
      tick(1);
    end
    apb_write(12'h000, 32'h2);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (led !== 4'h0) begin n_fail++; $display("FAIL loop_stop_led k=%0d: got %0h want 0", k, led); end
      tick(1);
    end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL loop_stop_status: got %0h want 0", rd); end
  endtask

  task automatic test_stop_wins();
    logic [31:0] rd;
    apb_write(12'h004, 32'd2);
    apb_write(12'h00C, 32'd7);
    apb_write(12'h000, 32'h5);
    tick(5);
    apb_write(12'h000, 32'h3);
    n_cmp++; if (led !== 4'h0) begin n_fail++; $display("FAIL stopwin_led: got %0h want 0", led); end
    tick(6);
    n_cmp++; if (led !== 4'h0) begin n_fail++; $display("FAIL stopwin_norestart: got %0h want 0", led); end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL stopwin_status: got %0h want 0", rd); end
  endtask

  task automatic test_done_race();
    logic [31:0] rd;
    apb_write(12'h004, 32'd2);
    apb_write(12'h00C, 32'd0);
    apb_write(12'h000, 32'h9);
    // This clear lands on the same edge that sets DONE (2 cycles after START).
    apb_write(12'h008, 32'h100);
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h102) begin n_fail++; $display("FAIL race_status: got %0h want 102", rd); end
    apb_read(12'h000, rd);
    n_cmp++; if (rd !== (IRQ_BUILD ? 32'h8 : 32'h0)) begin
      n_fail++; $display("FAIL irqen_read: got %0h want %0h", rd, IRQ_BUILD ? 32'h8 : 32'h0);
    end
    tick(4);
    n_cmp++; if (irq !== IRQ_BUILD) begin n_fail++; $display("FAIL race_irq: got %0b want %0b", irq, IRQ_BUILD); end
    apb_write(12'h008, 32'h100);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clear_irq: got %0b want 0", irq); end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL clear_status: got %0h want 2", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [3:0]  v;
    int          per, lastw, last;
    logic        loop;
    for (int t = 0; t < 5; t++) begin
      per   = $urandom_range(0, 4);
      lastw = $urandom_range(0, 15);
      last  = (lastw > NS - 1) ? NS - 1 : lastw;
      loop  = 1'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++) begin
        v = 4'($urandom_range(0, 15));
        apb_write(12'(64 + 4 * i), {28'd0, v});
        mpat[i] = v;
      end
      apb_write(12'h008, 32'h100);
      apb_write(12'h004, 32'(per));
      apb_write(12'h00C, 32'(lastw));
      apb_read(12'h00C, rd);
      n_cmp++; if (rd !== 32'(last)) begin n_fail++; $display("FAIL rnd_last t=%0d: got %0h want %0h", t, rd, last); end
      apb_write(12'h000, {29'd0, loop, 2'b01});
      for (int k = 0; k < 34; k++) begin
        n_cmp++; if (led !== exp_led(k, per, last, loop)) begin
          n_fail++; $display("FAIL rnd_led t=%0d k=%0d: got %0h want %0h", t, k, led, exp_led(k, per, last, loop));
        end
        tick(1);
      end
      apb_read(12'h008, rd);
      if (loop) begin
        n_cmp++; if (rd[1:0] !== 2'd1 || rd[8] !== 1'b0) begin n_fail++; $display("FAIL rnd_run_status t=%0d: got %0h want state 1", t, rd); end
      end else begin
        n_cmp++; if (rd !== (32'h102 | 32'(last << 4))) begin
          n_fail++; $display("FAIL rnd_done_status t=%0d: got %0h want %0h", t, rd, 32'h102 | 32'(last << 4));
        end
      end
      apb_write(12'h000, 32'h2);
      n_cmp++; if (led !== 4'h0) begin n_fail++; $display("FAIL rnd_stop_led t=%0d: got %0h want 0", t, led); end
      apb_read(12'h008, rd);
      n_cmp++; if (rd !== (loop ? 32'h0 : 32'h100)) begin
        n_fail++; $display("FAIL rnd_stop_status t=%0d: got %0h want %0h", t, rd, loop ? 32'h0 : 32'h100);
      end
    end
  endtask

  task automatic test_pattern_rewrite();
    logic [3:0] oldv, newv, ev;
    int         s;
    apb_write(12'h008, 32'h100);
    apb_write(12'h004, 32'd8);
    apb_write(12'h00C, 32'd2);
    apb_write(12'h000, 32'h5);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (led !== exp_led(k, 8, 2, 1'b1)) begin
        n_fail++; $display("FAIL rew_pre k=%0d: got %0h want %0h", k, led, exp_led(k, 8, 2, 1'b1));
      end
      tick(1);
    end
    oldv = mpat[1];
    newv = oldv ^ 4'($urandom_range(1, 15));
    apb_write(12'h044, {28'd0, newv});
    // The write edge is 10 cycles after START; only step loads after it see newv.
    for (int k = 10; k < 41; k++) begin
      s  = (k / 8) % 3;
      ev = (s == 1) ? (((k / 8) * 8 > 10) ? newv : oldv) : mpat[s];
      n_cmp++; if (led !== ev) begin n_fail++; $display("FAIL rew_led k=%0d: got %0h want %0h", k, led, ev); end
      tick(1);
    end
    mpat[1] = newv;
    apb_write(12'h000, 32'h2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    apb_write(12'h004, 32'd1);
    apb_write(12'h00C, 32'd7);
    apb_write(12'h000, 32'h5);
    tick(3);
    PRESETn = 1'b0;
    tick(1);
    n_cmp++; if (led !== 4'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got led=%0h irq=%0b want 0/0", led, irq); end
    PRESETn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      n_cmp++; if (led !== 4'h0) begin n_fail++; $display("FAIL midrst_hold k=%0d: got %0h want 0", k, led); end
    end
    apb_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_period: got %0h want 0", rd); end
    apb_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_status: got %0h want 0", rd); end
    apb_read(12'h044, rd);
    n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL midrst_pattern1: got %0h want 2", rd); end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_sequence();
    test_loop();
    test_stop_wins();
    test_done_race();
    test_random();
    test_pattern_rewrite();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
